// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared constants and block type for the TX gearbox feeder
package tx_pkg;

    localparam logic [1:0]  SYNC_DATA  = 2'b01;
    localparam logic [1:0]  SYNC_CTRL  = 2'b10;
    localparam logic [63:0] IDLE_BLOCK = 64'h1E00_0000_0000_0000;
    localparam int          SEQ_MAX    = 65;

    // x^58 + x^39 + 1: taps index the shift history, bit 0 being the newest bit
    localparam int SCR_LEN   = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef struct packed {
        logic [1:0]  head;
        logic [63:0] data;
    } block_t;

endpackage

// File: rtl/tx_gearbox_feeder_if.sv
// rtl/tx_gearbox_feeder_if.sv - block input stream and gearbox-facing word stream
interface tx_gearbox_feeder_if;

    logic [63:0] s_data_i;
    logic [1:0]  s_head_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] tx_data_o;
    logic [1:0]  tx_head_o;
    logic [6:0]  tx_sequence_o;
    logic        idle_ins_o;

    modport master (
        output s_data_i, s_head_i, s_valid_i,
        input  s_ready_o, tx_data_o, tx_head_o, tx_sequence_o, idle_ins_o
    );

    modport slave (
        input  s_data_i, s_head_i, s_valid_i,
        output s_ready_o, tx_data_o, tx_head_o, tx_sequence_o, idle_ins_o
    );

endinterface

// File: rtl/scrambler_64b.sv
// rtl/scrambler_64b.sv - self-synchronous x^58+x^39+1 scrambler, 64 bits per enable
module scrambler_64b
    import tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] d_i,
    output logic [63:0] d_o
);

    logic [SCR_LEN-1:0] state_q;
    logic [SCR_LEN-1:0] state_d;

    // Bit 0 is first in time; each scrambled bit feeds the history immediately
    always_comb begin
        state_d = state_q;
        d_o     = '0;
        for (int i = 0; i < 64; i++) begin
            d_o[i]  = d_i[i] ^ state_d[SCR_TAP_A] ^ state_d[SCR_TAP_B];
            state_d = {state_d[SCR_LEN-2:0], d_o[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '1;
        end else if (en) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/tx_gearbox_feeder.sv
// rtl/tx_gearbox_feeder.sv - feeds 64b blocks as 32b word pairs with sequence count to the 66b/64b gearbox
module tx_gearbox_feeder
    import tx_pkg::*;
#(
    parameter bit          P_SCRAMBLE   = 1'b1,
    parameter int          P_SEQ_MAX    = SEQ_MAX,
    parameter logic [63:0] P_IDLE_BLOCK = IDLE_BLOCK
) (
    input  logic                clk,
    input  logic                rst,
    tx_gearbox_feeder_if.slave  bus
);

    localparam logic [6:0] CNT_LAST  = 7'(P_SEQ_MAX);
    localparam logic [6:0] CNT_PAUSE = 7'(P_SEQ_MAX - 1);

    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  seq_q;
    logic [31:0] data_q, data_d;
    logic [31:0] low_q, low_d;
    logic [1:0]  head_q, head_d;
    logic        idle_q, idle_d;

    logic        pause;
    logic        slot;
    logic        second;
    logic        accept;
    block_t      blk;
    logic [63:0] scr_data;

    // The last two counts give the gearbox room for its two extra header bits
    assign pause  = (cnt_q >= CNT_PAUSE);
    assign slot   = ~rst & ~cnt_q[0] & ~pause;
    assign second = cnt_q[0] & ~pause;
    assign accept = slot & bus.s_valid_i;

    assign bus.s_ready_o = slot;

    always_comb begin
        blk = '0;
        if (accept) begin
            blk.head = bus.s_head_i;
            blk.data = bus.s_data_i;
        end else begin
            blk.head = SYNC_CTRL;
            blk.data = P_IDLE_BLOCK;
        end
    end

    generate
        if (P_SCRAMBLE) begin : g_scr
            scrambler_64b u_scr (
                .clk (clk),
                .rst (rst),
                .en  (slot),
                .d_i (blk.data),
                .d_o (scr_data)
            );
        end else begin : g_bypass
            assign scr_data = blk.data;
        end
    endgenerate

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? 7'd0 : cnt_q + 7'd1;
        data_d = '0;
        low_d  = low_q;
        head_d = head_q;
        idle_d = slot & ~bus.s_valid_i;
        if (slot) begin
            data_d = scr_data[63:32];
            low_d  = scr_data[31:0];
            head_d = blk.head;
        end else if (second) begin
            data_d = low_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            seq_q  <= '0;
            data_q <= '0;
            low_q  <= '0;
            head_q <= '0;
            idle_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            seq_q  <= cnt_q;
            data_q <= data_d;
            low_q  <= low_d;
            head_q <= head_d;
            idle_q <= idle_d;
        end
    end

    assign bus.tx_data_o     = data_q;
    assign bus.tx_head_o     = head_q;
    assign bus.tx_sequence_o = seq_q;
    assign bus.idle_ins_o    = idle_q;

endmodule

// File: tb/tb_tx_gearbox_feeder.sv
// tb/tb_tx_gearbox_feeder.sv - randomized self-checking bench for tx_gearbox_feeder
module tb_tx_gearbox_feeder;

    localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tx_gearbox_feeder_if if_raw ();
    tx_gearbox_feeder_if if_scr ();

    tx_gearbox_feeder #(.P_SCRAMBLE(1'b0)) u_dut_raw (
        .clk (clk),
        .rst (rst),
        .bus (if_raw)
    );

    tx_gearbox_feeder #(.P_SCRAMBLE(1'b1)) u_dut_scr (
        .clk (clk),
        .rst (rst),
        .bus (if_scr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: cycles since reset release and scrambled-bit history
    int          m_age = 0;
    bit          hist[$];
    logic [31:0] exp_data_raw, exp_data_scr, low_raw, low_scr;
    logic [1:0]  exp_head;
    logic [6:0]  exp_seq;
    logic        exp_idle;
    int          hs_obs = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void hist_reset();
        hist = {};
        for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    endfunction

    // scrambled bit n = data bit n ^ scrambled bit n-39 ^ scrambled bit n-58
    function automatic logic [63:0] model_scramble(input logic [63:0] d);
        logic [63:0] s;
        for (int i = 0; i < 64; i++) begin
            s[i] = d[i] ^ hist[19] ^ hist[0];
            hist.push_back(s[i]);
            void'(hist.pop_front());
        end
        return s;
    endfunction

    function automatic int phase();
        return m_age % 66;
    endfunction

    function automatic bit is_slot();
        return (phase() % 2 == 0) && (phase() < 64);
    endfunction

    task automatic run_cycle(input bit r, input bit v, input logic [63:0] d, input logic [1:0] h);
        int          ph;
        bit          slot;
        logic [63:0] blk, scr;
        rst = r;
        if_raw.s_valid_i = v; if_raw.s_data_i = d; if_raw.s_head_i = h;
        if_scr.s_valid_i = v; if_scr.s_data_i = d; if_scr.s_head_i = h;
        #1;
        ph   = phase();
        slot = !r && is_slot();
        check("ready_raw", if_raw.s_ready_o, slot);
        check("ready_scr", if_scr.s_ready_o, slot);
        if (if_raw.s_valid_i && if_raw.s_ready_o) hs_obs++;
        if (r) begin
            exp_data_raw = '0; exp_data_scr = '0; exp_head = '0; exp_seq = '0; exp_idle = 1'b0;
            m_age = 0;
            hist_reset();
        end else begin
            exp_seq  = 7'(ph);
            exp_idle = slot && !v;
            if (slot) begin
                blk      = v ? d : IDLE;
                exp_head = v ? h : 2'b10;
                scr      = model_scramble(blk);
                exp_data_raw = blk[63:32]; low_raw = blk[31:0];
                exp_data_scr = scr[63:32]; low_scr = scr[31:0];
            end else if (ph < 64) begin
                exp_data_raw = low_raw;
                exp_data_scr = low_scr;
            end else begin
                exp_data_raw = '0;
                exp_data_scr = '0;
            end
            m_age++;
        end
        @(posedge clk);
        #1;
        check("data_raw", if_raw.tx_data_o, exp_data_raw);
        check("data_scr", if_scr.tx_data_o, exp_data_scr);
        check("head_raw", if_raw.tx_head_o, exp_head);
        check("head_scr", if_scr.tx_head_o, exp_head);
        check("seq_raw", if_raw.tx_sequence_o, exp_seq);
        check("seq_scr", if_scr.tx_sequence_o, exp_seq);
        check("idle_raw", if_raw.idle_ins_o, exp_idle);
        check("idle_scr", if_scr.idle_ins_o, exp_idle);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(1'b0, ($urandom_range(3) != 0), {$urandom, $urandom},
                      ($urandom_range(1) != 0) ? 2'b01 : 2'b10);
    endtask

    initial begin
        logic [63:0] cnt_payload;
        logic [63:0] blk_a;
        int          idle_cnt;
        int          slots_left;

        hist_reset();
        exp_data_raw = '0; exp_data_scr = '0; low_raw = '0; low_scr = '0;
        exp_head = '0; exp_seq = '0; exp_idle = 1'b0;

        // reset state
        repeat (3) run_cycle(1'b1, 1'b0, 64'd0, 2'b00);

        // continuous valid, incrementing payload
        cnt_payload = 64'd0;
        for (int i = 0; i < 132; i++) begin
            if (i == 66) hs_obs = 0;
            run_cycle(1'b0, 1'b1, cnt_payload, 2'b01);
            if (exp_idle == 1'b0 && (i % 66) < 64 && (i % 2) == 0) cnt_payload++;
        end
        check("hs_per_66", hs_obs, 32);
        check("payload_count", cnt_payload, 64);

        // five idle slots
        hs_obs     = 0;
        idle_cnt   = 0;
        slots_left = 5;
        while (slots_left > 0) begin
            if (is_slot()) slots_left--;
            run_cycle(1'b0, 1'b0, {$urandom, $urandom}, 2'b01);
            idle_cnt += int'(if_raw.idle_ins_o);
        end
        check("idle_pulses", idle_cnt, 5);
        check("idle_hs", hs_obs, 0);

        run_random(400);

        // hold block A across the pause
        while (phase() != 63) run_cycle(1'b0, 1'b0, 64'd0, 2'b01);
        blk_a  = 64'hA5A5_0123_4567_5A5A;
        hs_obs = 0;
        repeat (3) run_cycle(1'b0, 1'b1, blk_a, 2'b01);
        check("hold_no_hs", hs_obs, 0);
        run_cycle(1'b0, 1'b1, blk_a, 2'b01);
        check("hold_hs", hs_obs, 1);
        check("hold_a_hi", if_raw.tx_data_o, blk_a[63:32]);
        check("hold_a_seq0", if_raw.tx_sequence_o, 0);
        run_cycle(1'b0, 1'b0, 64'd0, 2'b01);
        check("hold_a_lo", if_raw.tx_data_o, blk_a[31:0]);
        check("hold_a_seq1", if_raw.tx_sequence_o, 1);

        // reset mid-block, then zero payload from a fresh scrambler
        while (phase() != 31) run_random(1);
        repeat (3) run_cycle(1'b1, 1'b1, 64'd0, 2'b01);
        check("rst_ready", if_raw.s_ready_o, 0);
        run_cycle(1'b0, 1'b1, 64'd0, 2'b01);
        check("rst_seq0", if_scr.tx_sequence_o, 0);
        check("rst_raw_zero", if_raw.tx_data_o, 0);
        repeat (70) run_cycle(1'b0, 1'b1, 64'd0, 2'b01);

        run_random(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
